io_uart_tx: RTL and testbench
=============================

# io_uart_tx

Memory-mapped UART transmitter peripheral occupying the start of the SoC IO window (`IO_LO`). It sits directly downstream of the core's data-memory port: the core stores bytes to it, and it serialises them on `o_tx` as 8N1 frames through an internal FIFO. The core polls a status register to pace its writes. This makes program output observable on a real pin and in simulation without dumping RAM.

## Interface
- `XLEN`, default 32: bus address/data width.
- `BASE_ADDR`, default `IO_LO`: byte address of register offset 0.
- `CLKS_PER_BIT`, default 868: `i_clk` cycles per UART bit. Legal range is 2 to 65535.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Power of 2, from 2 to 128.

Ports:
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  bus write strobe, one cycle per access.
- `i_rd_en`  in  1  bus read strobe, one cycle per access.
- `i_addr`  in  XLEN  byte address.
- `i_wr_data`  in  XLEN  write data.
- `o_rd_data`  out  XLEN  read data, registered.
- `o_tx`  out  1  serial line, idle high.

## Operation
- **Address decode.** The block is selected when `i_addr` is in `BASE_ADDR` to `BASE_ADDR+11` and `i_addr[1:0]==0`. Unselected or misaligned accesses are ignored and read back 0.
- **Register map (offsets):**
  - 0x0 TXDATA, write-only: pushes `i_wr_data[7:0]`. Reads return 0.
  - 0x4 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, other bits 0. Writing 1 to bit3 clears overflow; other written bits are ignored.
  - 0x8 CTRL: bit0 enable, reset value 0. Reads return the stored value.
- **FIFO.** Uses circular read/write pointers with a count.
  - A push when full and no pop in the same cycle is dropped and sets overflow.
  - A push and a pop in the same cycle when full: both occur and the count is unchanged.
  - A push into an empty FIFO is not poppable in the same cycle.
- **TX FSM states: IDLE, START, DATA, STOP.**
  - IDLE → START: enable=1 and FIFO non-empty. On this edge the FIFO pops into an 8-bit shift register, `o_tx` goes to 0, and the baud counter loads `CLKS_PER_BIT-1`.
  - The baud counter decrements every cycle. When it reaches 0 it reloads and the bit phase advances.
  - START → DATA after 1 bit time. DATA sends 8 bits LSB first, shifting right, with a 3-bit index.
  - DATA → STOP after the 8th bit. STOP drives `o_tx=1` for 1 bit time.
  - End of STOP with enable=1 and FIFO non-empty: pop and go straight to START, with no idle gap. Otherwise go to IDLE.
  - Clearing enable mid-frame does not abort the frame: it completes, then the FSM stays in IDLE.
- **Reset.** Asynchronous and immediate, including mid-frame.
  - `o_tx`=1, `o_rd_data`=0.
  - FIFO emptied, pointers and count 0.
  - overflow=0, enable=0, FSM in IDLE.

## Timing
- Write at edge N: the entry is visible in count and the empty flag after N.
- If idle and enabled, the pop happens at edge N+1 and `o_tx` falls at N+1.
- Frame length is exactly `10*CLKS_PER_BIT` cycles: start bit, 8 data bits, stop bit. busy goes to 0 on the edge that ends STOP when the FSM returns to IDLE.
- Read latency is 1 cycle. `i_rd_en` at edge N gives `o_rd_data` valid after N, holding a snapshot of the state before edge N. `o_rd_data` holds its value until the next read.
- Simultaneous read and write in one cycle: the read returns the pre-write state.
- `o_tx` is driven from a register and is glitch-free.

## Test plan
- **Reset state.** Assert `i_rst` for 2 cycles, release, read 0x4 → 0x00000002. Read 0x8 → 0. `o_tx`=1 throughout.
- **Single frame.** `CLKS_PER_BIT`=4. Write CTRL=1, then TXDATA=0xA5 at edge N.
  - `o_tx` from edge N+1 is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - busy=0 read at N+41.
- **Overflow and full.** `FIFO_DEPTH`=8, enable=0, write 9 bytes.
  - STATUS = 0x00000809: count 8, full, overflow.
  - Write 0x8 to STATUS → 0x00000801.
  - Enable, then receive the first 8 bytes in order, 0x01..0x08; the 9th is absent.
- **Back-to-back frames.** Write 0x55 and 0x0F with enable=1. The two frames are contiguous: the second start bit directly follows the first stop bit, total 80 cycles at `CLKS_PER_BIT`=4.
- **Disable mid-frame.** Queue 2 bytes and clear enable during the first frame's DATA phase.
  - The first frame completes and `o_tx` stays 1.
  - count=1 and busy=0.
  - Re-enable → second frame begins 1 cycle later.
- **Reset mid-frame.** Assert `i_rst` during DATA bit 3. `o_tx`=1 immediately, without waiting for a clock edge. After release, STATUS=0x2 and no frame occurs.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register map: 0x0 TXDATA (write-only), 0x4 STATUS, 0x8 CTRL.
module io_uart_tx #(
  parameter int unsigned     XLEN         = 32,
  // Start of the SoC IO window (IO_LO).
  parameter logic [XLEN-1:0] BASE_ADDR    = XLEN'(32'h1000_0000),
  parameter int unsigned     CLKS_PER_BIT = 868,
  parameter int unsigned     FIFO_DEPTH   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic            i_rd_en,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf, r_en;
  state_t          r_state, w_state_nx;
  logic [15:0]     r_baud, w_baud_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [2:0]      r_idx, w_idx_nx;
  logic            r_tx, w_tx_nx;
  logic [XLEN-1:0] r_rd_data;

  logic [XLEN-1:0] w_off, w_status, w_rd_val;
  logic            w_sel, w_wr_txdata, w_wr_status, w_wr_ctrl;
  logic            w_push, w_pop, w_full, w_empty, w_tick, w_unused;

  // Address decode: 3 aligned words starting at BASE_ADDR.
  assign w_off       = i_addr - BASE_ADDR;
  assign w_sel       = (i_addr >= BASE_ADDR) && (w_off < XLEN'(12)) && (i_addr[1:0] == 2'b00);
  assign w_wr_txdata = i_wr_en && w_sel && (w_off[3:2] == 2'd0);
  assign w_wr_status = i_wr_en && w_sel && (w_off[3:2] == 2'd1);
  assign w_wr_ctrl   = i_wr_en && w_sel && (w_off[3:2] == 2'd2);
  assign w_unused    = ^i_wr_data[XLEN-1:8];

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a push when the FSM pops in the same cycle.
  assign w_push  = w_wr_txdata && (!w_full || w_pop);
  assign w_tick  = (r_baud == 16'd0);

  // FIFO storage; not reset, only the pointers and count define contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data[7:0];
  end

  // FIFO pointers, count, sticky overflow and enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_txdata && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_status && i_wr_data[3]) r_ovf <= 1'b0;
      if (w_wr_ctrl) r_en <= i_wr_data[0];
    end
  end

  // Status word and read-data mux from pre-edge state.
  always_comb begin
    w_status        = '0;
    w_status[0]     = w_full;
    w_status[1]     = w_empty;
    w_status[2]     = (r_state != S_IDLE);
    w_status[3]     = r_ovf;
    w_status[15:8]  = 8'(r_count);
    w_rd_val        = '0;
    if (w_sel) begin
      case (w_off[3:2])
        2'd1:    w_rd_val = w_status;
        2'd2:    w_rd_val = {{(XLEN-1){1'b0}}, r_en};
        default: w_rd_val = '0;
      endcase
    end
  end

  // Registered read port; holds until the next read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= w_rd_val;
  end

  // TX FSM next-state, baud counter, shifter and line level.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_en && !w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rptr];
          w_tx_nx    = 1'b0;
          w_baud_nx  = BAUD_RELOAD;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_baud_nx = w_tick ? BAUD_RELOAD : r_baud - 16'd1;
        if (w_tick) begin
          w_tx_nx    = r_shift[0];
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_idx_nx   = 3'd0;
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        w_baud_nx = w_tick ? BAUD_RELOAD : r_baud - 16'd1;
        if (w_tick) begin
          if (r_idx == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_tx_nx    = r_shift[0];
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_idx_nx   = r_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_baud_nx = w_tick ? BAUD_RELOAD : r_baud - 16'd1;
        if (w_tick) begin
          // Chain straight into the next frame when data is waiting.
          if (r_en && !w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rptr];
            w_tx_nx    = 1'b0;
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
    endcase
  end

  // TX FSM state register; line forced idle-high by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_shift <= w_shift_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_tx      = r_tx;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed bench for io_uart_tx with a byte scoreboard
// filled on TXDATA writes and drained by a serial-line receiver.
module tb_io_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;

  logic        i_clk, i_rst, i_wr_en, i_rd_en;
  logic [31:0] i_addr, i_wr_data, o_rd_data, rdv;
  logic        o_tx;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  io_uart_tx #(
    .XLEN(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data), .o_tx(o_tx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_addr = a; i_wr_data = d; i_wr_en = 1'b1;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    i_addr = a; i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    d = o_rd_data;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, expv);
  endtask

  // Walks one frame cycle by cycle; the first 'skip' cycles are already checked.
  task automatic chk_frame(input string tag, input logic [7:0] b, input int skip);
    logic bitv;
    for (int i = 0; i < 10*CPB; i++) begin
      if (i >= skip) begin
        if (i / CPB == 0)      bitv = 1'b0;
        else if (i / CPB == 9) bitv = 1'b1;
        else                   bitv = b[i/CPB - 1];
        tick();
        check(tag, {31'b0, o_tx}, {31'b0, bitv});
      end
    end
  endtask

  // Serial receiver: samples mid-bit and pops the scoreboard per frame.
  initial begin : mon
    bit         busy;
    int         cnt;
    logic [7:0] rx, ex_b;
    busy = 0; cnt = 0; rx = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst === 1'b1) busy = 0;
      else if (!busy) begin
        if (o_tx === 1'b0) begin busy = 1; cnt = 0; end
      end else begin
        cnt++;
        for (int b = 0; b < 8; b++)
          if (cnt == CPB + CPB/2 + CPB*b) rx[b] = o_tx;
        if (cnt == 9*CPB + CPB/2) begin
          check("rx_stop", {31'b0, o_tx}, 32'd1);
          check("rx_expected_frame", {31'b0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            ex_b = sb.pop_front();
            check("rx_byte", {24'b0, rx}, {24'b0, ex_b});
          end
        end
        if (cnt == 10*CPB - 1) busy = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    i_rst = 1'b1; i_wr_en = 1'b0; i_rd_en = 1'b0; i_addr = '0; i_wr_data = '0;
    // Reset state
    #1;
    check("rst_tx", {31'b0, o_tx}, 32'd1);
    tick(); check("rst_tx", {31'b0, o_tx}, 32'd1);
    tick(); check("rst_tx", {31'b0, o_tx}, 32'd1);
    check("rst_rd_data", o_rd_data, 32'd0);
    i_rst = 1'b0;
    rdchk("rst_status", A_ST, 32'h0000_0002);
    rdchk("rst_ctrl", A_CT, 32'd0);

    // Decode: misaligned/out-of-window accesses ignored, read 0
    wr(BASE + 32'd1, 32'h41);
    wr(BASE + 32'd12, 32'h42);
    wr(BASE - 32'd4, 32'h43);
    wr(BASE + 32'd9, 32'h1);
    rdchk("decode_status", A_ST, 32'h0000_0002);
    rdchk("decode_ctrl", A_CT, 32'd0);
    rdchk("decode_unsel", BASE + 32'd12, 32'd0);
    rdchk("decode_misal", BASE + 32'd4 + 32'd1, 32'd0);
    rdchk("txdata_read", A_TX, 32'd0);
    rdchk("status_again", A_ST, 32'h0000_0002);
    repeat (3) tick();
    check("rd_hold", o_rd_data, 32'h0000_0002);

    // Single frame 0xA5
    wr(A_CT, 32'd1);
    sb.push_back(8'hA5);
    wr(A_TX, 32'hA5);
    chk_frame("frame_a5", 8'hA5, 0);
    tick();
    check("after_frame_tx", {31'b0, o_tx}, 32'd1);
    rdchk("single_idle", A_ST, 32'h0000_0002);

    // Overflow and full
    wr(A_CT, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back(8'(i));
      wr(A_TX, 32'(i));
    end
    rdchk("ovf_status", A_ST, 32'h0000_0809);
    i_addr = A_ST; i_wr_data = 32'h8; i_wr_en = 1'b1; i_rd_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    check("rw_same_cycle", o_rd_data, 32'h0000_0809);
    rdchk("ovf_cleared", A_ST, 32'h0000_0801);
    wr(A_ST, 32'hFFFF_FFF7);
    rdchk("status_ro_bits", A_ST, 32'h0000_0801);
    wr(A_CT, 32'd1);
    repeat (5) tick();
    rdchk("drain_busy", A_ST, 32'h0000_0704);
    repeat (8*10*CPB + 10 - 6) tick();
    check("drain_sb_empty", sb.size(), 32'd0);
    rdchk("drain_idle", A_ST, 32'h0000_0002);

    // Back-to-back frames
    sb.push_back(8'h55);
    sb.push_back(8'h0F);
    wr(A_TX, 32'h55);
    wr(A_TX, 32'h0F);
    check("b2b_start", {31'b0, o_tx}, 32'd0);
    chk_frame("b2b_first", 8'h55, 1);
    chk_frame("b2b_second", 8'h0F, 0);
    tick();
    check("b2b_end_tx", {31'b0, o_tx}, 32'd1);
    rdchk("b2b_idle", A_ST, 32'h0000_0002);

    // Disable mid-frame
    sb.push_back(8'h3C);
    sb.push_back(8'h96);
    wr(A_TX, 32'h3C);
    wr(A_TX, 32'h96);
    repeat (8) tick();
    wr(A_CT, 32'd0);
    repeat (35) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dis_tx_idle", {31'b0, o_tx}, 32'd1);
    end
    rdchk("dis_status", A_ST, 32'h0000_0100);
    wr(A_CT, 32'd1);
    check("reen_same_edge", {31'b0, o_tx}, 32'd1);
    tick();
    check("reen_start", {31'b0, o_tx}, 32'd0);
    repeat (10*CPB + 5) tick();
    rdchk("reen_idle", A_ST, 32'h0000_0002);

    // Reset mid-frame during data bit 3 of 0xC3
    wr(A_TX, 32'hC3);
    repeat (17) tick();
    #3;
    check("pre_reset_tx", {31'b0, o_tx}, 32'd0);
    i_rst = 1'b1;
    #1;
    check("async_reset_tx", {31'b0, o_tx}, 32'd1);
    tick();
    tick();
    i_rst = 1'b0;
    rdchk("post_reset_status", A_ST, 32'h0000_0002);
    rdchk("post_reset_ctrl", A_CT, 32'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      check("post_reset_quiet", {31'b0, o_tx}, 32'd1);
    end

    check("sb_final_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
